// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types and helpers for the interrupt dispatch controller
package int_pkg;
  localparam int INT_LINES = 4;

  typedef enum logic {IDLE, REQ} state_t;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [1:0] highest_bit(input logic [INT_LINES-1:0] v);
    highest_bit = 2'd0;
    for (int i = 0; i < INT_LINES; i++) begin
      if (v[i]) highest_bit = i[1:0];
    end
  endfunction
endpackage

// File: rtl/int_dispatch_ctrl_if.sv
// rtl/int_dispatch_ctrl_if.sv - dispatch handshake between interrupt controller and PC logic
interface int_dispatch_ctrl_if;
  logic        int_req;
  logic        int_ack;
  logic [1:0]  int_num;
  logic [31:0] int_vector;

  modport master (output int_req, output int_num, output int_vector, input int_ack);
  modport slave  (input int_req, input int_num, input int_vector, output int_ack);
endinterface

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - fixed-priority encoder, bit 3 highest
module int_prio_enc
  import int_pkg::*;
(
  input  logic [INT_LINES-1:0] vec,
  output logic                 valid,
  output logic [1:0]           idx
);
  assign valid = |vec;
  assign idx   = highest_bit(vec);
endmodule

// File: rtl/int_dispatch_ctrl.sv
// rtl/int_dispatch_ctrl.sv - interrupt capture, arbitration and vector dispatch
// Optional nesting of higher-priority lines over in-service ones: INT_NEST_EN.
module int_dispatch_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] VEC0     = 32'h0000_0578,
  parameter logic [31:0] VEC1     = 32'h0000_0640,
  parameter logic [31:0] VEC2     = 32'h0000_02EE,
  parameter logic [31:0] VEC3     = 32'h0000_03B6,
  parameter int unsigned ERET_GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INT_LINES-1:0] ir,
  input  logic [INT_LINES-1:0] mask,
  input  logic                 ie,
  input  logic                 eret,
  int_dispatch_ctrl_if.master  bus,
  output logic [INT_LINES-1:0] int_pending,
  output logic [INT_LINES-1:0] in_service
);
  localparam logic [3:0] GAP_INIT = 4'(ERET_GAP);

  state_t                 state, state_nxt;
  logic [INT_LINES-1:0]   ir_q, rise, eligible, pending_nxt, service_nxt;
  logic [3:0]             gap_cnt;
  logic [1:0]             num_q, p_idx, s_idx;
  logic [31:0]            vector_q;
  logic                   p_valid, s_valid, gate, take_ack, load;

  function automatic logic [31:0] vec_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_sel = VEC0;
      2'd1:    vec_sel = VEC1;
      2'd2:    vec_sel = VEC2;
      default: vec_sel = VEC3;
    endcase
  endfunction

  assign rise     = ir & ~ir_q;
  assign eligible = (ie && gap_cnt == 4'd0) ? (int_pending & mask) : '0;
  assign take_ack = (state == REQ) && bus.int_ack;

  int_prio_enc u_enc_elig (.vec(eligible),   .valid(p_valid), .idx(p_idx));
  int_prio_enc u_enc_svc  (.vec(in_service), .valid(s_valid), .idx(s_idx));

`ifdef INT_NEST_EN
  assign gate = p_valid && (!s_valid || (p_idx > s_idx));
`else
  assign gate = p_valid && !s_valid;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (gate) begin
        state_nxt = REQ;
        load      = 1'b1;
      end
      REQ: if (take_ack || !ie) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ERET retires against in_service as it was before this cycle's ack lands.
  always_comb begin
    pending_nxt = int_pending;
    service_nxt = in_service;
    if (take_ack) pending_nxt[num_q] = 1'b0;
    pending_nxt = pending_nxt | rise;
    if (eret && s_valid) service_nxt[s_idx] = 1'b0;
    if (take_ack) service_nxt[num_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ir_q        <= '0;
      int_pending <= '0;
      in_service  <= '0;
      gap_cnt     <= 4'd0;
      num_q       <= 2'd0;
      vector_q    <= VEC0;
    end else begin
      state       <= state_nxt;
      ir_q        <= ir;
      int_pending <= pending_nxt;
      in_service  <= service_nxt;
      if (eret)                 gap_cnt <= GAP_INIT;
      else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      if (load) begin
        num_q    <= p_idx;
        vector_q <= vec_sel(p_idx);
      end
    end
  end

  assign bus.int_req    = (state == REQ);
  assign bus.int_num    = num_q;
  assign bus.int_vector = vector_q;
endmodule

// File: tb/tb_int_dispatch_ctrl.sv
// tb/tb_int_dispatch_ctrl.sv - directed table-driven bench for int_dispatch_ctrl
module tb_int_dispatch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ir = '0, mask = '0;
  logic       ie = 1'b0, eret = 1'b0;
  logic [3:0] int_pending, in_service;
  int         checks = 0;
  int         errors = 0;

  int_dispatch_ctrl_if bus ();

  int_dispatch_ctrl dut (
    .clk(clk), .rst(rst), .ir(ir), .mask(mask), .ie(ie), .eret(eret),
    .bus(bus), .int_pending(int_pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ir;
    logic [3:0] mask;
    logic       ie, eret, ack;
    logic       req;
    logic [1:0] num;
    logic [3:0] pend, svc;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [3:0] i, input logic [3:0] m, input logic e,
                              input logic r, input logic a, input logic q,
                              input logic [1:0] n, input logic [3:0] p, input logic [3:0] s);
    vec_t v;
    v.ir = i; v.mask = m; v.ie = e; v.eret = r; v.ack = a;
    v.req = q; v.num = n; v.pend = p; v.svc = s;
    return v;
  endfunction

  function automatic logic [31:0] vec_of(input logic [1:0] n);
    case (n)
      2'd0:    return 32'h0000_0578;
      2'd1:    return 32'h0000_0640;
      2'd2:    return 32'h0000_02EE;
      default: return 32'h0000_03B6;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic req, input logic [1:0] num,
                            input logic [3:0] pend, input logic [3:0] svc);
    chk({tag, ".int_req"},     32'(bus.int_req),    32'(req));
    chk({tag, ".int_num"},     32'(bus.int_num),    32'(num));
    chk({tag, ".int_vector"},  bus.int_vector,      vec_of(num));
    chk({tag, ".int_pending"}, 32'(int_pending),    32'(pend));
    chk({tag, ".in_service"},  32'(in_service),     32'(svc));
  endtask

  task automatic step(input logic [3:0] i, input logic [3:0] m, input logic e,
                      input logic r, input logic a);
    ir = i; mask = m; ie = e; eret = r; bus.int_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.int_ack = 1'b0;
    // ir mask ie eret ack | req num pend svc
    tbl[0]  = mk(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000);
    tbl[1]  = mk(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000);
    tbl[2]  = mk(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000);
    tbl[3]  = mk(4'b0001, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001);
    tbl[4]  = mk(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
    tbl[6]  = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
    tbl[7]  = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1010, 4'b0000);
    tbl[8]  = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0010, 4'b1000);
    tbl[9]  = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b1000);
    tbl[10] = mk(4'b1011, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b0000);
    tbl[11] = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b0000);
    tbl[12] = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b0000);
    tbl[13] = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000);
    tbl[14] = mk(4'b1011, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0010);
    tbl[15] = mk(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000);
    tbl[16] = mk(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b1000, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000);
    tbl[18] = mk(4'b1000, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000);
    tbl[19] = mk(4'b1000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
    tbl[20] = mk(4'b1000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b0000);
    tbl[21] = mk(4'b1000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b0000);
    tbl[22] = mk(4'b1000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
    tbl[23] = mk(4'b1000, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b1000);
    tbl[24] = mk(4'b1000, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b1000);
    tbl[25] = mk(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    tbl[26] = mk(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    tbl[27] = mk(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);

    #12;
    expect_all("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 28; k++) begin
      step(tbl[k].ir, tbl[k].mask, tbl[k].ie, tbl[k].eret, tbl[k].ack);
      expect_all($sformatf("tbl%0d", k), tbl[k].req, tbl[k].num, tbl[k].pend, tbl[k].svc);
    end

    // eret and ack in the same cycle: neither event is lost
    step(4'b0010, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.cap",  1'b0, 2'd3, 4'b0010, 4'b0000);
    step(4'b0010, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.req",  1'b1, 2'd1, 4'b0010, 4'b0000);
    step(4'b0010, 4'hF, 1'b1, 1'b1, 1'b1); expect_all("ea.both", 1'b0, 2'd1, 4'b0000, 4'b0010);
    step(4'b0110, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.gap",  1'b0, 2'd1, 4'b0100, 4'b0010);
    step(4'b0110, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("ea.eret", 1'b0, 2'd1, 4'b0100, 4'b0000);
    step(4'b0110, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.g1",   1'b0, 2'd1, 4'b0100, 4'b0000);
    step(4'b0110, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.g2",   1'b0, 2'd1, 4'b0100, 4'b0000);
    step(4'b0110, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("ea.disp", 1'b1, 2'd2, 4'b0100, 4'b0000);
    step(4'b0110, 4'hF, 1'b1, 1'b0, 1'b1); expect_all("ea.ack",  1'b0, 2'd2, 4'b0000, 4'b0100);
    step(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("ea.ret",  1'b0, 2'd2, 4'b0000, 4'b0000);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);

    // line 0 in service, then line 2 rises
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.cap0", 1'b0, 2'd2, 4'b0001, 4'b0000);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.req0", 1'b1, 2'd0, 4'b0001, 4'b0000);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b1); expect_all("n.ack0", 1'b0, 2'd0, 4'b0000, 4'b0001);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.cap2", 1'b0, 2'd0, 4'b0100, 4'b0001);
`ifdef INT_NEST_EN
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.req2", 1'b1, 2'd2, 4'b0100, 4'b0001);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b1); expect_all("n.ack2", 1'b0, 2'd2, 4'b0000, 4'b0101);
    step(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("n.ret2", 1'b0, 2'd2, 4'b0000, 4'b0001);
    step(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("n.ret0", 1'b0, 2'd2, 4'b0000, 4'b0000);
`else
    for (int k = 0; k < 3; k++) begin
      step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0);
      expect_all($sformatf("n.hold%0d", k), 1'b0, 2'd0, 4'b0100, 4'b0001);
    end
    step(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("n.ret0", 1'b0, 2'd0, 4'b0100, 4'b0000);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.gap1", 1'b0, 2'd0, 4'b0100, 4'b0000);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.gap2", 1'b0, 2'd0, 4'b0100, 4'b0000);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("n.req2", 1'b1, 2'd2, 4'b0100, 4'b0000);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b1); expect_all("n.ack2", 1'b0, 2'd2, 4'b0000, 4'b0100);
    step(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0); expect_all("n.ret2", 1'b0, 2'd2, 4'b0000, 4'b0000);
`endif
    step(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);

    // asynchronous reset with line 0 in service and line 2 pending or requested
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b1); expect_all("r.svc0", 1'b0, 2'd0, 4'b0000, 4'b0001);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0);
`ifdef INT_NEST_EN
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("r.inreq", 1'b1, 2'd2, 4'b0100, 4'b0001);
`endif
    bus.int_ack = 1'b0;
    #1 rst = 1'b0;
    #1 expect_all("r.async", 1'b0, 2'd0, 4'b0000, 4'b0000);
    #1 rst = 1'b1;
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("r.held", 1'b0, 2'd0, 4'b0101, 4'b0000);
    step(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0); expect_all("r.disp", 1'b1, 2'd2, 4'b0101, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
